// File: rtl/serial_to_parallel_converter.sv
// Purpose: collects N serial bits (valid/ready) into a parallel word held in a one-word output register.
// Latency: the word is presented right after the edge that accepts its last bit, with no extra pipeline stage.
// Backpressure: only the completing bit stalls while the output is occupied; par_ready reaches ser_ready combinationally.
module serial_to_parallel_converter #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ser_data,
    input  logic         ser_valid,
    output logic         ser_ready,
    output logic [N-1:0] par_data,
    output logic         par_valid,
    input  logic         par_ready
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sh;
    logic [N-1:0]  sh_ins;
    logic [CW-1:0] cnt;
    logic          last;
    logic          ser_acc;
    logic          par_acc;
    logic          word_done;

    assign last      = (cnt == LAST);
    assign par_valid = (state == HOLD);
    // The completing bit may enter only if the output slot is free or being drained this cycle.
    assign ser_ready = !par_valid || par_ready || !last;
    assign ser_acc   = ser_valid && ser_ready;
    assign par_acc   = par_valid && par_ready;
    assign word_done = ser_acc && last;

    // Shift-register value with the incoming bit applied, in the configured bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_ins = {sh[N-2:0], ser_data};
        end else begin : g_lsb
            assign sh_ins = {ser_data, sh[N-1:1]};
        end
    endgenerate

    // Shift in each accepted bit and track the position within the word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh  <= '0;
            cnt <= '0;
        end else if (ser_acc) begin
            sh  <= sh_ins;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    // Load the completed word; held stable otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_data <= '0;
        end else if (word_done) begin
            par_data <= sh_ins;
        end
    end

    // Output slot state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output slot next state: a new word wins over a simultaneous drain.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (word_done) state_nxt = HOLD;
            HOLD:    if (par_acc && !word_done) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Directed bench for serial_to_parallel_converter: MSB-first instance for most scenarios,
// plus an LSB-first instance for bit-order checking.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_serial_to_parallel_converter;

    logic       clk;
    logic       rstn;
    logic       ser_data, ser_valid, par_ready;
    logic       ser_ready, par_valid;
    logic [3:0] par_data;
    logic       ser_data2, ser_valid2, par_ready2;
    logic       ser_ready2, par_valid2;
    logic [3:0] par_data2;

    int checks;
    int failures;

    serial_to_parallel_converter #(.N(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready)
    );

    serial_to_parallel_converter #(.N(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn),
        .ser_data(ser_data2), .ser_valid(ser_valid2), .ser_ready(ser_ready2),
        .par_data(par_data2), .par_valid(par_valid2), .par_ready(par_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit, clock it, then deassert valid; sampling point is #1 after the edge.
    task automatic send_bit(input logic b);
        ser_data  = b;
        ser_valid = 1'b1;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic garbage);
        ser_data  = garbage;
        ser_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #2;
        checks++;
        if (par_valid !== 1'b0) begin failures++; $display("FAIL reset_par_valid got=%b exp=0", par_valid); end
        checks++;
        if (par_data !== 4'b0000) begin failures++; $display("FAIL reset_par_data got=%b exp=0000", par_data); end
        checks++;
        if (ser_ready !== 1'b1) begin failures++; $display("FAIL reset_ser_ready got=%b exp=1", ser_ready); end
        checks++;
        if (ser_ready2 !== 1'b1 || par_valid2 !== 1'b0) begin
            failures++; $display("FAIL reset_lsb_inst got rdy=%b vld=%b exp rdy=1 vld=0", ser_ready2, par_valid2);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_word;
        logic [3:0] bits;
        bits = 4'b1011;
        par_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i != 0) begin
                checks++;
                if (par_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid bit=%0d got=%b exp=0", i, par_valid); end
            end
        end
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b1011) begin
            failures++; $display("FAIL basic_word got vld=%b data=%b exp vld=1 data=1011", par_valid, par_data);
        end
        idle_cycle(1'b0);
        checks++;
        if (par_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_end got=%b exp=0", par_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits;
        bits = 8'b1011_1101;
        par_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            ser_data  = bits[i];
            ser_valid = 1'b1;
            #1;
            checks++;
            if (ser_ready !== 1'b1) begin failures++; $display("FAIL b2b_ser_ready bit=%0d got=%b exp=1", 7 - i, ser_ready); end
            @(posedge clk);
            #1;
            if (i == 4) begin
                checks++;
                if (par_valid !== 1'b1 || par_data !== 4'b1011) begin
                    failures++; $display("FAIL b2b_word1 got vld=%b data=%b exp vld=1 data=1011", par_valid, par_data);
                end
            end else if (i == 0) begin
                checks++;
                if (par_valid !== 1'b1 || par_data !== 4'b1101) begin
                    failures++; $display("FAIL b2b_word2 got vld=%b data=%b exp vld=1 data=1101", par_valid, par_data);
                end
            end else begin
                checks++;
                if (par_valid !== 1'b0) begin failures++; $display("FAIL b2b_spurious_valid bit=%0d got=%b exp=0", 7 - i, par_valid); end
            end
        end
        ser_valid = 1'b0;
        idle_cycle(1'b0);
    endtask

    task automatic test_backpressure;
        logic [3:0] w1;
        logic [3:0] w2;
        w1 = 4'b1011;
        w2 = 4'b0110;
        par_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(w1[i]);
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b1011) begin
            failures++; $display("FAIL bp_word1 got vld=%b data=%b exp vld=1 data=1011", par_valid, par_data);
        end
        for (int i = 3; i >= 1; i--) begin
            send_bit(w2[i]);
            checks++;
            if (par_valid !== 1'b1 || par_data !== 4'b1011) begin
                failures++; $display("FAIL bp_hold_stable bit=%0d got vld=%b data=%b exp vld=1 data=1011", 3 - i, par_valid, par_data);
            end
        end
        ser_data  = w2[0];
        ser_valid = 1'b1;
        #1;
        checks++;
        if (ser_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", ser_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b1011) begin
            failures++; $display("FAIL bp_stalled_edge got vld=%b data=%b exp vld=1 data=1011", par_valid, par_data);
        end
        par_ready = 1'b1;
        #1;
        checks++;
        if (ser_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ser_ready); end
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b0110) begin
            failures++; $display("FAIL bp_replace got vld=%b data=%b exp vld=1 data=0110", par_valid, par_data);
        end
        idle_cycle(1'b0);
        checks++;
        if (par_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", par_valid); end
    endtask

    task automatic test_gapped;
        logic [3:0] bits;
        bits = 4'b1101;
        par_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i != 0) begin
                checks++;
                if (par_valid !== 1'b0) begin failures++; $display("FAIL gap_spurious_valid bit=%0d got=%b exp=0", 3 - i, par_valid); end
                for (int g = 0; g < 4 - i; g++) begin
                    idle_cycle(~bits[i] ^ g[0]);
                    checks++;
                    if (par_valid !== 1'b0) begin failures++; $display("FAIL gap_idle_valid gap=%0d got=%b exp=0", g, par_valid); end
                end
            end
        end
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b1101) begin
            failures++; $display("FAIL gap_word got vld=%b data=%b exp vld=1 data=1101", par_valid, par_data);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_reset_mid;
        logic [3:0] bits;
        // Park a word in the output slot, then start the next word.
        par_ready = 1'b0;
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) send_bit(bits[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (par_valid !== 1'b0) begin failures++; $display("FAIL rstmid_par_valid got=%b exp=0", par_valid); end
        checks++;
        if (par_data !== 4'b0000) begin failures++; $display("FAIL rstmid_par_data got=%b exp=0000", par_data); end
        checks++;
        if (ser_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ser_ready got=%b exp=1", ser_ready); end
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        par_ready = 1'b1;
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i != 0) begin
                checks++;
                if (par_valid !== 1'b0) begin failures++; $display("FAIL rstmid_partial_kept bit=%0d got=%b exp=0", 3 - i, par_valid); end
            end
        end
        checks++;
        if (par_valid !== 1'b1 || par_data !== 4'b0110) begin
            failures++; $display("FAIL rstmid_word got vld=%b data=%b exp vld=1 data=0110", par_valid, par_data);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_lsb_first;
        logic [3:0] seq;
        seq = 4'b1101;  // sent left to right: 1,1,0,1
        par_ready2 = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            ser_data2  = seq[i];
            ser_valid2 = 1'b1;
            @(posedge clk);
            #1;
        end
        ser_valid2 = 1'b0;
        checks++;
        if (par_valid2 !== 1'b1 || par_data2 !== 4'b1011) begin
            failures++; $display("FAIL lsb_word got vld=%b data=%b exp vld=1 data=1011", par_valid2, par_data2);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        ser_data   = 1'b0;
        ser_valid  = 1'b0;
        par_ready  = 1'b1;
        ser_data2  = 1'b0;
        ser_valid2 = 1'b0;
        par_ready2 = 1'b1;
        test_reset();
        test_basic_word();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
